// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC flit encodings and transmitter state type
package noc_pkg;

    localparam int LEN_W_DEF = 12;

    localparam logic [2:0] FLIT_IDLE = 3'b000;
    localparam logic [2:0] FLIT_HEAD = 3'b001;
    localparam logic [2:0] FLIT_BODY = 3'b010;
    localparam logic [2:0] FLIT_TAIL = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEAD,
        ST_BODY,
        ST_TAIL,
        ST_GAP
    } tx_state_t;

endpackage

// File: rtl/flit_tx_fifo.sv
// rtl/flit_tx_fifo.sv - synchronous payload FIFO with full/empty flags
module flit_tx_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              do_push;
    logic              do_pop;

    // Extra pointer MSB distinguishes full from empty.
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/flit_tx.sv
// rtl/flit_tx.sv - network-interface transmitter slicing packets into header/body/tail flits
module flit_tx
    import noc_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int LEN_W      = LEN_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_valid,
    output logic              pkt_ready,
    input  logic [LEN_W-1:0]  pkt_words,
    input  logic              pay_valid,
    output logic              pay_ready,
    input  logic [DATA_W-1:0] pay_data,
    input  logic              grant,
    output logic              req,
    output logic [2:0]        flit_id,
    output logic [LEN_W-1:0]  length,
    output logic              flit_valid,
    output logic [DATA_W-1:0] flit_data,
    output logic              err_len,
    output logic [15:0]       pkt_count
);
    tx_state_t         state_q, state_d;
    logic [LEN_W-1:0]  p_q, p_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [LEN_W-1:0]  length_q, length_d;
    logic [15:0]       pkt_count_q, pkt_count_d;
    logic              err_len_q, err_len_d;
    logic              idle_ready;
    logic              flit_move;
    logic              pop;
    logic              push;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;

    // Slot freed by a same-cycle pop may be refilled immediately.
    assign pay_ready = ~rst & (~fifo_full | pop);
    assign push      = pay_valid & pay_ready;
    assign pkt_ready = idle_ready & ~rst;

    flit_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (pay_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        rem_d       = rem_q;
        length_d    = length_q;
        pkt_count_d = pkt_count_q;
        err_len_d   = 1'b0;
        idle_ready  = 1'b0;
        req         = 1'b0;
        flit_id     = FLIT_IDLE;
        flit_move   = 1'b0;
        pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idle_ready = 1'b1;
                if (pkt_valid) begin
                    if (pkt_words == '0) begin
                        err_len_d = 1'b1;
                    end else begin
                        p_d      = pkt_words;
                        rem_d    = pkt_words;
                        length_d = pkt_words + LEN_W'(1);
                        state_d  = ST_HEAD;
                    end
                end
            end
            ST_HEAD: begin
                req       = 1'b1;
                flit_id   = FLIT_HEAD;
                flit_move = grant;
                if (grant) begin
                    state_d = (p_q >= LEN_W'(2)) ? ST_BODY : ST_TAIL;
                end
            end
            ST_BODY: begin
                req       = 1'b1;
                flit_id   = FLIT_BODY;
                flit_move = grant & ~fifo_empty;
                if (flit_move) begin
                    pop   = 1'b1;
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_d == LEN_W'(1)) begin
                        state_d = ST_TAIL;
                    end
                end
            end
            ST_TAIL: begin
                req       = 1'b1;
                flit_id   = FLIT_TAIL;
                flit_move = grant & ~fifo_empty;
                if (flit_move) begin
                    pop         = 1'b1;
                    pkt_count_d = pkt_count_q + 16'd1;
                    state_d     = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            p_q         <= '0;
            rem_q       <= '0;
            length_q    <= '0;
            pkt_count_q <= '0;
            err_len_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            rem_q       <= rem_d;
            length_q    <= length_d;
            pkt_count_q <= pkt_count_d;
            err_len_q   <= err_len_d;
        end
    end

    assign length     = length_q;
    assign err_len    = err_len_q;
    assign pkt_count  = pkt_count_q;
    assign flit_valid = flit_move;
    assign flit_data  = (state_q == ST_HEAD) ? DATA_W'(p_q) :
                        (state_q == ST_BODY || state_q == ST_TAIL) ? fifo_rdata : '0;

endmodule

// File: tb/tb_flit_tx.sv
// tb/tb_flit_tx.sv - randomized self-checking bench for flit_tx against a packet-level model
module tb_flit_tx;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 12;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              pkt_valid;
    logic              pkt_ready;
    logic [LEN_W-1:0]  pkt_words;
    logic              pay_valid;
    logic              pay_ready;
    logic [DATA_W-1:0] pay_data;
    logic              grant;
    logic              req;
    logic [2:0]        flit_id;
    logic [LEN_W-1:0]  length;
    logic              flit_valid;
    logic [DATA_W-1:0] flit_data;
    logic              err_len;
    logic [15:0]       pkt_count;

    flit_tx #(
        .DATA_W     (DATA_W),
        .LEN_W      (LEN_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .pkt_words  (pkt_words),
        .pay_valid  (pay_valid),
        .pay_ready  (pay_ready),
        .pay_data   (pay_data),
        .grant      (grant),
        .req        (req),
        .flit_id    (flit_id),
        .length     (length),
        .flit_valid (flit_valid),
        .flit_data  (flit_data),
        .err_len    (err_len),
        .pkt_count  (pkt_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Packet-level model: payload queue plus position within the current packet.
    logic [31:0] m_q[$];
    bit          m_in_pkt;
    bit          m_gap;
    bit          m_err;
    int          m_idx;
    int          m_p;
    int          m_cnt;
    int          flits_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_in_pkt = 0;
        m_gap    = 0;
        m_err    = 0;
        m_idx    = 0;
        m_p      = 0;
        m_cnt    = 0;
    endtask

    task automatic step(input bit pv, input int pw, input bit yv, input logic [31:0] yd, input bit g);
        bit          idle;
        bit          mv;
        bit          pops;
        bit          rdy_pay;
        logic [2:0]  eid;
        logic [31:0] edata;
        @(negedge clk);
        pkt_valid = pv;
        pkt_words = pw[LEN_W-1:0];
        pay_valid = yv;
        pay_data  = yd;
        grant     = g;
        #1;
        idle    = !m_in_pkt && !m_gap;
        mv      = m_in_pkt && g && (m_idx == 0 || m_q.size() > 0);
        pops    = mv && (m_idx > 0);
        rdy_pay = (m_q.size() < DEPTH) || pops;
        if (!m_in_pkt)          eid = 3'b000;
        else if (m_idx == 0)    eid = 3'b001;
        else if (m_idx == m_p)  eid = 3'b100;
        else                    eid = 3'b010;
        check("req", req, m_in_pkt);
        check("pkt_ready", pkt_ready, idle);
        check("pay_ready", pay_ready, rdy_pay);
        check("flit_valid", flit_valid, mv);
        check("flit_id", flit_id, eid);
        check("err_len", err_len, m_err);
        check("pkt_count", pkt_count, m_cnt & 32'hffff);
        if (m_in_pkt) check("length", length, (m_p + 1) & ((1 << LEN_W) - 1));
        if (mv) begin
            flits_seen++;
            if (m_idx == 0) edata = m_p;
            else            edata = m_q[0];
            check("flit_data", flit_data, edata);
        end
        m_err = idle && pv && (pw == 0);
        if (m_gap) m_gap = 0;
        if (mv) begin
            if (pops) void'(m_q.pop_front());
            if (m_idx == m_p) begin
                m_in_pkt = 0;
                m_gap    = 1;
                m_cnt++;
            end else begin
                m_idx++;
            end
        end
        if (idle && pv && pw != 0) begin
            m_in_pkt = 1;
            m_idx    = 0;
            m_p      = pw;
        end
        if (yv && rdy_pay) m_q.push_back(yd);
    endtask

    task automatic drain(input bit yv);
        for (int i = 0; i < 60 && (m_in_pkt || m_gap); i++) step(0, 0, yv, $urandom, 1);
    endtask

    initial begin
        rst = 1'b1; pkt_valid = 0; pkt_words = '0; pay_valid = 0; pay_data = '0; grant = 0;
        model_clear();
        flits_seen = 0;
        #1;
        check("rst_req", req, 0);
        check("rst_flit_id", flit_id, 0);
        check("rst_length", length, 0);
        check("rst_flit_valid", flit_valid, 0);
        check("rst_flit_data", flit_data, 0);
        check("rst_err_len", err_len, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_pkt_ready", pkt_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // P=3 preloaded, grant tied high
        for (int i = 0; i < 3; i++) step(0, 0, 1, $urandom, 1);
        step(1, 3, 0, 0, 1);
        drain(0);
        step(0, 0, 0, 0, 1);
        check("cnt_after_p3", pkt_count, 1);

        // P=1: header then tail
        step(0, 0, 1, $urandom, 1);
        step(1, 1, 0, 0, 1);
        drain(0);

        // P=0: dropped with err_len
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // P=4 with grant dropped after the second body
        for (int i = 0; i < 4; i++) step(0, 0, 1, $urandom, 1);
        flits_seen = 0;
        step(1, 4, 0, 0, 1);
        for (int i = 0; i < 20 && m_in_pkt && m_idx < 3; i++) step(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        drain(0);
        check("flits_p4", flits_seen, 5);

        // P=3 with payload stalled two cycles before word B
        step(0, 0, 1, $urandom, 1);
        step(1, 3, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, $urandom, 1);
        step(0, 0, 1, $urandom, 1);
        drain(0);

        // Fill FIFO while idle, then drain with pushes concurrent to pops
        for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 1, $urandom, 0);
        step(1, 4, 1, $urandom, 0);
        drain(1);

        // Asynchronous reset between two body flits
        step(1, 3, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_req", req, 0);
        check("arst_flit_valid", flit_valid, 0);
        check("arst_flit_id", flit_id, 0);
        check("arst_flit_data", flit_data, 0);
        check("arst_pkt_count", pkt_count, 0);
        check("arst_pkt_ready", pkt_ready, 0);
        check("arst_length", length, 0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 1, $urandom, 1);
        step(0, 0, 1, $urandom, 1);
        step(1, 2, 0, 0, 1);
        drain(0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 5),
                 $urandom_range(0, 4) < 3, $urandom, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 80 && (m_in_pkt || m_gap); i++) step(0, 0, 1, $urandom, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
